// File: rtl/cpu_pkg.sv
// Shared datapath constants for the integer register file and its neighbours.
package cpu_pkg;

   localparam int REG_AW = 5;
   localparam int DATA_W = 64;
   localparam int NREG   = 32;

   // Register 31 is hardwired to zero; writes to it are discarded.
   localparam logic [REG_AW-1:0] XZR = 5'd31;

endpackage

// File: rtl/regfile_2r1w_mux.sv
// 32-to-1 selector of N-bit words, used once per read port of the register file.
module Mux32to1Nbit #(
   parameter int N = 64
) (
   input  logic [31:0][N-1:0] data,
   input  logic [4:0]         sel,
   output logic [N-1:0]       out
);

   assign out = data[sel];

endmodule

// File: rtl/regfile_2r1w.sv
// 32 x N register file: two registered read ports, one write port, XZR at index 31,
// and same-edge write-to-read forwarding.
module regfile_2r1w
   import cpu_pkg::*;
#(
   parameter int N    = DATA_W,
   parameter int NREG = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_en,
   input  logic              stall,
   input  logic [REG_AW-1:0] ra,
   input  logic [REG_AW-1:0] rb,
   input  logic              we,
   input  logic [REG_AW-1:0] wa,
   input  logic [N-1:0]      wd,
   output logic [N-1:0]      da,
   output logic [N-1:0]      db,
   output logic              rd_valid
);

   logic [NREG-1:0][N-1:0] regs;
   logic [N-1:0]           mux_a;
   logic [N-1:0]           mux_b;
   logic [N-1:0]           next_da;
   logic [N-1:0]           next_db;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         regs <= '0;
      end else if (we && (wa != XZR)) begin
         regs[wa] <= wd;
      end
   end

   Mux32to1Nbit #(.N(N)) u_mux_a (
      .data (regs),
      .sel  (ra),
      .out  (mux_a)
   );

   Mux32to1Nbit #(.N(N)) u_mux_b (
      .data (regs),
      .sel  (rb),
      .out  (mux_b)
   );

   // Zero-register check wins over the bypass so a dropped write to 31 never leaks out.
   always_comb begin
      next_da = mux_a;
      next_db = mux_b;
      if (ra == XZR) begin
         next_da = '0;
      end else if (we && (wa == ra)) begin
         next_da = wd;
      end
      if (rb == XZR) begin
         next_db = '0;
      end else if (we && (wa == rb)) begin
         next_db = wd;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         da       <= '0;
         db       <= '0;
         rd_valid <= 1'b0;
      end else if (!stall) begin
         rd_valid <= rd_en;
         if (rd_en) begin
            da <= next_da;
            db <= next_db;
         end
      end
   end

endmodule
